// File: rtl/mont_pkg.sv
// Shared constants, FSM encoding and adder request payload for montgomery_mult.
//   WIDTH     operand/modulus width
//   ADD_W     adder datapath width (WIDTH+2)
//   CNT_BITS  iteration counter width
//   ADDER_LAT cycles from adder start to adder done
package mont_pkg;

  localparam int unsigned WIDTH     = 512;
  localparam int unsigned ADD_W     = WIDTH + 2;
  localparam int unsigned CNT_BITS  = 9;
  localparam int unsigned ADDER_LAT = 4;
  localparam int unsigned LAT_BITS  = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADD_B  = 3'd1,
    WAIT_B = 3'd2,
    ADD_M  = 3'd3,
    WAIT_M = 3'd4,
    SUB_M  = 3'd5,
    WAIT_S = 3'd6,
    FIN    = 3'd7
  } state_t;

  // One adder operation as presented on the adder inputs.
  typedef struct packed {
    logic             start;
    logic             subtract;
    logic             shift;
    logic [ADD_W-1:0] op_b;
  } add_req_t;

endpackage

// File: rtl/adder.sv
// Multi-cycle wide adder: result = (in_a +/- in_b) [>> 1], done pulses
// ADDER_LAT cycles after start. Inputs must stay stable until done.
//   clk, resetn          clock, synchronous active-low reset
//   start                1-cycle operation request
//   subtract, shift      operation select
//   in_a, in_b           ADD_W-bit operands
//   result               ADD_W+1-bit result, valid while done=1
//   done                 1-cycle completion pulse
module adder
  import mont_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             subtract,
  input  logic             shift,
  input  logic [ADD_W-1:0] in_a,
  input  logic [ADD_W-1:0] in_b,
  output logic [ADD_W:0]   result,
  output logic             done
);

  logic [LAT_BITS-1:0] cnt;
  logic                run;
  logic [ADD_W:0]      raw_c;
  logic [ADD_W:0]      sum_c;

  // Full-width sum/difference; the shift keeps the carry-out bit.
  always_comb begin
    raw_c = subtract ? ({1'b0, in_a} - {1'b0, in_b})
                     : ({1'b0, in_a} + {1'b0, in_b});
    sum_c = shift ? (raw_c >> 1) : raw_c;
  end

  // Latency counter; result is captured on the last counted cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      run    <= 1'b0;
      cnt    <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        run <= 1'b1;
        cnt <= LAT_BITS'(1);
      end else if (run) begin
        if (cnt == LAT_BITS'(ADDER_LAT - 1)) begin
          result <= sum_c;
          done   <= 1'b1;
          run    <= 1'b0;
          cnt    <= '0;
        end else begin
          cnt <= cnt + LAT_BITS'(1);
        end
      end
    end
  end

endmodule

// File: rtl/montgomery_mult.sv
// Bit-serial Montgomery multiplier: result = A*B*2^-WIDTH mod M (M odd, B < M).
// Sequences every add, add+shift and final subtract through one adder instance.
//   clk, reset     clock, synchronous active-high reset
//   start          1-cycle request, in_a/in_b/in_m sampled when accepted
//   in_a/in_b/in_m multiplier, multiplicand, modulus
//   result         product, valid at done and held until next accepted start
//   done           1-cycle completion pulse
//   busy           high from accepted start until the done cycle
module montgomery_mult
  import mont_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy
);

  localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(WIDTH - 1);

  state_t              state, state_n;
  logic [WIDTH-1:0]    a_r, b_r, m_r;
  logic [ADD_W-1:0]    c_r;
  logic [CNT_BITS-1:0] i_r;
  add_req_t            req_c;
  logic [ADD_W:0]      add_res;
  logic                add_done;
  logic                unused_ok;

  // Carry-out of the adder and the consumed LSB of the scan register are not needed.
  assign unused_ok = ^{add_res[ADD_W], a_r[0]};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state. a_r[1] is the next multiplier bit because a_r shifts on leaving WAIT_M.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = in_a[0] ? ADD_B : ADD_M;
      ADD_B:   state_n = WAIT_B;
      WAIT_B:  if (add_done) state_n = ADD_M;
      ADD_M:   state_n = WAIT_M;
      WAIT_M:  if (add_done) state_n = (i_r == LAST) ? SUB_M : (a_r[1] ? ADD_B : ADD_M);
      SUB_M:   state_n = WAIT_S;
      WAIT_S:  if (add_done) state_n = FIN;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Adder request decode; held constant across the issue and wait states of each op.
  always_comb begin
    req_c = '0;
    unique case (state)
      ADD_B, WAIT_B: req_c.op_b = {2'b00, b_r};
      ADD_M, WAIT_M: begin
        req_c.shift = 1'b1;
        req_c.op_b  = c_r[0] ? {2'b00, m_r} : '0;
      end
      SUB_M, WAIT_S: begin
        req_c.subtract = 1'b1;
        req_c.op_b     = {2'b00, m_r};
      end
      default: req_c = '0;
    endcase
    req_c.start = (state == ADD_B) || (state == ADD_M) || (state == SUB_M);
  end

  adder u_adder (
    .clk      (clk),
    .resetn   (~reset),
    .start    (req_c.start),
    .subtract (req_c.subtract),
    .shift    (req_c.shift),
    .in_a     (c_r),
    .in_b     (req_c.op_b),
    .result   (add_res),
    .done     (add_done)
  );

  // Operand, accumulator, counter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r    <= '0;
      b_r    <= '0;
      m_r    <= '0;
      c_r    <= '0;
      i_r    <= '0;
      result <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          a_r  <= in_a;
          b_r  <= in_b;
          m_r  <= in_m;
          c_r  <= '0;
          i_r  <= '0;
          busy <= 1'b1;
        end
        WAIT_B: if (add_done) c_r <= add_res[ADD_W-1:0];
        WAIT_M: if (add_done) begin
          c_r <= add_res[ADD_W-1:0];
          if (i_r != LAST) begin
            i_r <= i_r + CNT_BITS'(1);
            a_r <= {1'b0, a_r[WIDTH-1:1]};
          end
        end
        // Negative difference (bit ADD_W-1 set) keeps C.
        WAIT_S: if (add_done && !add_res[ADD_W-1]) c_r <= add_res[ADD_W-1:0];
        FIN: begin
          result <= c_r[WIDTH-1:0];
          done   <= 1'b1;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Accumulator stays below 2M after every reduction step.
  always_ff @(posedge clk) begin
    if (!reset && state == WAIT_M && add_done)
      assert (!add_res[ADD_W-1] && (add_res[ADD_W-1:0] < {1'b0, m_r, 1'b0}));
  end

endmodule

// File: tb/tb_montgomery_mult.sv
module tb_montgomery_mult;

  localparam int W      = 512;
  localparam int BUDGET = 6000;

  typedef struct {
    logic [W-1:0] res;
    int unsigned  lat;
    int unsigned  t0;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] in_a = '0, in_b = '0, in_m = '0;
  logic [W-1:0] result;
  logic         done, busy;

  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  exp_t        exp_q[$];

  montgomery_mult dut (
    .clk(clk), .reset(reset), .start(start),
    .in_a(in_a), .in_b(in_b), .in_m(in_m),
    .result(result), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: A*B mod M, then multiply by 2^-W as W modular halvings.
  function automatic logic [W-1:0] mont_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] m);
    logic [2*W-1:0] p;
    logic [W+1:0]   x;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    p = p % {{W{1'b0}}, m};
    x = {2'b00, p[W-1:0]};
    for (int k = 0; k < W; k++)
      x = x[0] ? ((x + {2'b00, m}) >> 1) : (x >> 1);
    return x[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    for (int k = 0; k < W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act[63:0], req[63:0]);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: done=1 at cycle %0d with no request outstanding", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", result, e.res);
        check("latency", W'(cyc - e.t0), W'(e.lat));
        check("busy_at_done", W'(busy), W'(0));
      end
    end
  end

  // Drive one start pulse; an accepted request pushes its expectation.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m,
                       input bit accept);
    @(negedge clk);
    in_a = a; in_b = b; in_m = m; start = 1'b1;
    if (accept) begin
      exp_t e;
      e.res = mont_ref(a, b, m);
      e.lat = 5 * (W + $countones(a)) + 7;
      e.t0  = cyc;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    in_a = rand_w(); in_b = rand_w(); in_m = rand_w();
    check("busy_after_start", W'(busy), W'(1));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL timeout: %0d requests still pending after %0d cycles", exp_q.size(), n);
      exp_q.delete();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m);
    issue(a, b, m, 1'b1);
    wait_idle();
  endtask

  initial begin
    logic [W-1:0] mall, one, top, a, b, m;
    mall = '1;
    one  = W'(1);
    top  = one << (W - 1);

    repeat (3) @(negedge clk);
    check("reset_result", result, '0);
    check("reset_done", W'(done), W'(0));
    check("reset_busy", W'(busy), W'(0));
    reset = 1'b0;
    @(negedge clk);

    // Boundary cases around the all-ones modulus.
    run_one(one, W'(5), mall);
    run_one(top, W'(2), mall);
    m = rand_w() | one;
    run_one('0, m - one, m);
    run_one(mall, mall - one, mall);
    run_one(mall - one, mall - W'(2), mall);

    // Random odd moduli with B < M.
    for (int k = 0; k < 4; k++) begin
      m = rand_w() | one;
      b = rand_w() % m;
      a = rand_w();
      run_one(a, b, m);
    end

    // Reset during the first WAIT_B aborts silently.
    m = rand_w() | one;
    issue(rand_w() | one, rand_w() % m, m, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    check("abort_busy", W'(busy), W'(0));
    check("abort_done", W'(done), W'(0));
    check("abort_result", result, '0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    m = rand_w() | one;
    run_one(rand_w(), rand_w() % m, m);

    // A start while busy must be ignored.
    m = rand_w() | one;
    a = rand_w();
    b = rand_w() % m;
    issue(a, b, m, 1'b1);
    repeat (15) @(negedge clk);
    issue(rand_w(), rand_w(), rand_w() | one, 1'b0);
    wait_idle();

    // Back-to-back: new start on the done cycle.
    m = rand_w() | one;
    issue(rand_w(), rand_w() % m, m, 1'b1);
    begin
      int n = 0;
      while (!done && n < BUDGET) begin @(negedge clk); n++; end
      if (!done) begin
        total++; bad++;
        $display("FAIL b2b_timeout: done not seen after %0d cycles", n);
      end
    end
    m = rand_w() | one;
    in_a = rand_w(); in_b = rand_w() % m; in_m = m; start = 1'b1;
    begin
      exp_t e;
      e.res = mont_ref(in_a, in_b, in_m);
      e.lat = 5 * (W + $countones(in_a)) + 7;
      e.t0  = cyc;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", W'(busy), W'(1));
    wait_idle();

    check("queue_drained", W'(exp_q.size()), W'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
